// File: rtl/q_8_42_ones_gen.sv
// Ones generator: builds a WIDTH-bit, MSB-justified word with count_in ones, one bit per clock.
// Optional macro Q_8_42_OVF_FLAG_EN adds the ovf output that flags a clamped request.
module q_8_42_ones_gen #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic             rdy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
`ifdef Q_8_42_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] data_q;
  logic             over_d;

  // Requests above WIDTH are clamped so the shift never runs past a full word.
  always_comb begin
    over_d = (count_in > CW'(WIDTH));
    cnt_d  = over_d ? CW'(WIDTH) : count_in;
  end

`ifdef Q_8_42_OVF_FLAG_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef Q_8_42_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= cnt_d;
            data_q  <= '0;
            state_q <= S_FILL;
`ifdef Q_8_42_OVF_FLAG_EN
            ovf_q   <= over_d;
`endif
          end
        end
        S_FILL: begin
          if (cnt_q != '0) begin
            data_q <= {1'b1, data_q[WIDTH-1:1]};
            cnt_q  <= cnt_q - 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdy      = (state_q == S_IDLE);
  assign done     = (state_q == S_FILL) && (cnt_q == '0);
  assign data_out = data_q;

endmodule

// File: tb/tb_q_8_42_ones_gen.sv
// Scoreboard bench for q_8_42_ones_gen (WIDTH=8): stimulus pushes expected words, a monitor checks on done.
module tb_q_8_42_ones_gen;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CW-1:0]    count_in;
  logic             rdy;
  logic             done;
  logic [WIDTH-1:0] data_out;
`ifdef Q_8_42_OVF_FLAG_EN
  logic             ovf;
`endif

  q_8_42_ones_gen #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count_in (count_in),
    .rdy      (rdy),
    .done     (done),
    .data_out (data_out)
`ifdef Q_8_42_OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               n;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic rdy_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: records accept cycles, checks every done against the scoreboard.
  always @(negedge clk) begin
    if (rdy_chk) begin
      chk("rdy_after_done", int'(rdy), 1);
      rdy_chk = 1'b0;
    end
    if (!rst && rdy && start) acc_cyc = cyc + 1;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", int'(data_out), int'(e.data));
        chk("popcount", $countones(data_out), e.n);
        chk("latency", cyc - acc_cyc, e.n);
`ifdef Q_8_42_OVF_FLAG_EN
        chk("ovf", int'(ovf), int'(e.ovf));
`endif
        rdy_chk = 1'b1;
      end
    end
  end

  task automatic wait_rdy();
    int t = 0;
    while (!rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got rdy=0 expected rdy=1 within 100 cycles");
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || rdy_chk) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
  endtask

  // Issue one request; count_in is scrambled after acceptance to prove it is not re-sampled.
  task automatic run(input int n, input logic [WIDTH-1:0] want, input logic want_ovf);
    exp_t e;
    wait_rdy();
    e.data = want;
    e.n    = (n > WIDTH) ? WIDTH : n;
    e.ovf  = want_ovf;
    sb.push_back(e);
    start    = 1'b1;
    count_in = CW'(n);
    @(negedge clk);
    start    = 1'b0;
    count_in = CW'($urandom_range(0, 15));
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    count_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_rdy", int'(rdy), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_data", int'(data_out), 0);
`ifdef Q_8_42_OVF_FLAG_EN
    chk("reset_ovf", int'(ovf), 0);
`endif

    run(3, 8'hE0, 1'b0);
    run(0, 8'h00, 1'b0);
    run(8, 8'hFF, 1'b0);
    run(12, 8'hFF, 1'b1);
    run(2, 8'hC0, 1'b0);
    run(15, 8'hFF, 1'b1);
    run(7, 8'hFE, 1'b0);

    // start held high through the fill and the done cycle: exactly one done.
    begin
      exp_t e;
      int   t = 0;
      wait_rdy();
      e.data = 8'hF8;
      e.n    = 5;
      e.ovf  = 1'b0;
      sb.push_back(e);
      start    = 1'b1;
      count_in = 4'd5;
      @(negedge clk);
      count_in = 4'd1;
      while (!done && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) @(negedge clk);
      chk("no_requeue_rdy", int'(rdy), 1);
      chk("no_requeue_data", int'(data_out), 8'hF8);
      wait_drain();
    end

    // Reset two clocks into a 6-count fill aborts it silently.
    wait_rdy();
    start    = 1'b1;
    count_in = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdy", int'(rdy), 1);
    chk("abort_data", int'(data_out), 0);
    chk("abort_done", int'(done), 0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    run(1, 8'h80, 1'b0);

    // Round trip: 200 random counts, popcount must match the clamped request.
    for (int i = 0; i < 200; i++) begin
      int n;
      int m;
      n = $urandom_range(0, 15);
      m = (n > WIDTH) ? WIDTH : n;
      run(n, ~(8'hFF >> m), (n > WIDTH));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
